// File: rtl/select_int64_seq_if.sv
// Request/response bundle for the sequential bit-select unit.
interface select_int64_seq_if #(
  parameter int WIDTH = 64,
  parameter int PW    = $clog2(WIDTH),
  parameter int KW    = PW + 1
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [KW-1:0]    K;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    Y;
  logic             found;

  modport master (
    output in_valid, A, K, out_ready,
    input  in_ready, out_valid, Y, found
  );

  modport slave (
    input  in_valid, A, K, out_ready,
    output in_ready, out_valid, Y, found
  );
endinterface

// File: rtl/select_int64_seq.sv
// Select: position of the K-th set bit of A, scanning CHUNK bits per cycle.
// Latency: hit in chunk c -> out_valid c+2 cycles after the accept cycle; miss -> WIDTH/CHUNK+1.
// Backpressure: result held in DONE until out_ready; no new request accepted until then.
module select_int64_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8,
  parameter int PW    = $clog2(WIDTH),
  parameter int KW    = PW + 1
) (
  input logic               clk,
  input logic               rst,
  select_int64_seq_if.slave io
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW  = $clog2(CHUNK) + 1;
  localparam int CPW = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q;
  logic [KW-1:0]    rem_q, rem_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [PW-1:0]    y_q, y_d;
  logic             found_q, found_d;
  logic             load_a;

  logic [CHUNK-1:0] chunk;
  logic [CW-1:0]    cnt;
  logic [CPW-1:0]   pos;
  logic             hit;

  // One pass over the chunk yields both its popcount and the rem-th set bit position.
  always_comb begin
    chunk = a_q[idx_q*CHUNK +: CHUNK];
    cnt   = '0;
    pos   = '0;
    hit   = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (chunk[i]) begin
        if (!hit && (KW'(cnt) == rem_q)) begin
          hit = 1'b1;
          pos = CPW'(i);
        end
        cnt = cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    idx_d        = idx_q;
    y_d          = y_q;
    found_d      = found_q;
    load_a       = 1'b0;
    io.in_ready  = (state_q == IDLE);
    io.out_valid = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          load_a  = 1'b1;
          rem_d   = io.K;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (rem_q < KW'(cnt)) begin
          y_d     = PW'(int'(idx_q) * CHUNK + int'(pos));
          found_d = 1'b1;
          state_d = DONE;
        end else begin
          rem_d = rem_q - KW'(cnt);
          if (idx_q == IW'(NCH - 1)) begin
            y_d     = '0;
            found_d = 1'b0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      y_q     <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      found_q <= found_d;
      if (load_a) a_q <= io.A;
    end
  end

  assign io.Y     = y_q;
  assign io.found = found_q;
endmodule

// File: tb/tb_select_int64_seq.sv
// Directed and random checks of select_int64_seq against a bit-serial reference.
module tb_select_int64_seq;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  select_int64_seq_if #(.WIDTH(64)) bus ();

  select_int64_seq dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit-serial reference; latency derived from the chunk holding the answer.
  task automatic ref_sel(input logic [63:0] a, input logic [6:0] k,
                         output logic [5:0] y, output logic f, output int lat);
    int seen;
    seen = 0;
    y    = '0;
    f    = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (a[i] && !f) begin
        if (seen == int'(k)) begin
          f = 1'b1;
          y = 6'(i);
        end
        seen++;
      end
    end
    lat = f ? (int'(y) / 8) + 2 : 9;
  endtask

  // Issue one request, wait for result, check latency/Y/found, then complete handshake.
  task automatic run(input string tag, input logic [63:0] a, input logic [6:0] k,
                     input logic [5:0] exp_y, input logic exp_f, input int exp_lat);
    int n;
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.K        = k;
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 30) begin
      tick();
      n++;
    end
    check({tag, ".lat"}, 64'(n), 64'(exp_lat));
    check({tag, ".Y"}, 64'(bus.Y), 64'(exp_y));
    check({tag, ".found"}, 64'(bus.found), 64'(exp_f));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] ra;
    logic [6:0]  rk;
    logic [5:0]  ey;
    logic        ef;
    int          el;
    int          n;

    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.K = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset.in_ready", 64'(bus.in_ready), 64'd1);
    check("reset.out_valid", 64'(bus.out_valid), 64'd0);
    check("reset.Y", 64'(bus.Y), 64'd0);
    check("reset.found", 64'(bus.found), 64'd0);

    run("lsb", 64'h1, 7'd0, 6'd0, 1'b1, 2);
    run("ones_k63", '1, 7'd63, 6'd63, 1'b1, 9);
    run("ones_k64", '1, 7'd64, 6'd0, 1'b0, 9);
    run("ends_k1", 64'h8000_0000_0000_0001, 7'd1, 6'd63, 1'b1, 9);
    run("ends_k2", 64'h8000_0000_0000_0001, 7'd2, 6'd0, 1'b0, 9);
    run("zero", 64'h0, 7'd0, 6'd0, 1'b0, 9);
    run("bit40", 64'h0000_0100_0000_0000, 7'd0, 6'd40, 1'b1, 7);
    run("alt_k5", 64'hAAAA_AAAA_AAAA_AAAA, 7'd5, 6'd11, 1'b1, 3);
    run("k127", 64'hFFFF_0000_FFFF_0000, 7'd127, 6'd0, 1'b0, 9);

    // Backpressure: hold result in DONE while a competing request is presented.
    bus.in_valid = 1'b1;
    bus.A = 64'h0000_0000_0000_0300;
    bus.K = 7'd1;
    tick();
    bus.A = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.K = 7'd0;
    n = 1;
    while (!bus.out_valid && n < 30) begin
      tick();
      n++;
    end
    check("bp.lat", 64'(n), 64'd3);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp.out_valid", 64'(bus.out_valid), 64'd1);
      check("bp.Y", 64'(bus.Y), 64'd9);
      check("bp.found", 64'(bus.found), 64'd1);
      check("bp.in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp.release.in_ready", 64'(bus.in_ready), 64'd1);
    check("bp.release.out_valid", 64'(bus.out_valid), 64'd0);
    run("bp.next", 64'h0000_0100_0000_0000, 7'd0, 6'd40, 1'b1, 7);

    // Reset in the middle of a scan drops the pending result.
    bus.in_valid = 1'b1;
    bus.A = '1;
    bus.K = 7'd63;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.in_ready", 64'(bus.in_ready), 64'd1);
    check("rst.Y", 64'(bus.Y), 64'd0);
    check("rst.found", 64'(bus.found), 64'd0);
    for (int c = 0; c < 10; c++) tick();
    check("rst.dropped", 64'(bus.out_valid), 64'd0);
    run("rst.fresh", 64'h10, 7'd0, 6'd4, 1'b1, 2);

    for (int r = 0; r < 24; r++) begin
      ra = {$urandom, $urandom};
      if (r % 3 == 1) ra = ra & {$urandom, $urandom} & {$urandom, $urandom};
      rk = 7'($urandom_range(0, 80));
      ref_sel(ra, rk, ey, ef, el);
      run($sformatf("rand%0d", r), ra, rk, ey, ef, el);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
